mxu_systolic_core: RTL and testbench

//  Weight-stationary systolic multiply-accumulate array of M rows x K columns, the compute core of the matrix unit.

---
 rtl/mxu_systolic_core.sv | 109 ++++++++++
 tb/tb_mxu_systolic_core.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mxu_systolic_core.sv
// Weight-stationary M x K systolic MAC array. Activations enter on the left
// (skewed one cycle per row) and move right; partial sums move down each
// column; column outputs are deskewed so that all K results of one activation
// vector appear on y together, M+K enabled cycles after it was presented.
module mxu_systolic_core #(
  parameter int M              = 3,
  parameter int K              = 3,
  parameter int max_data_width = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [4:0]                  data_type,
  input  logic [M*max_data_width-1:0] input_data,
  input  logic [K*max_data_width-1:0] weight,
  output logic                        test_mode,
  output logic [K*max_data_width-1:0] y
);

  localparam int W = max_data_width;

  logic [M*W-1:0] a_vec;           // skewed activations entering column 0
  logic [W-1:0]   wreg [K];        // stationary weight per column
  logic [W-1:0]   d    [M][K];     // activation registers
  logic [W-1:0]   p    [M][K];     // partial-sum registers

  // Row 0 enters the array without delay.
  assign a_vec[W-1:0] = input_data[W-1:0];

  genvar gi, gj;

  // Row i is delayed by i enabled cycles before entering the array.
  for (gi = 1; gi < M; gi++) begin : g_skew
    logic [W-1:0] sr [gi];

    // Per-row skew shift register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sr <= '{default: '0};
      end else if (enable) begin
        sr[0] <= input_data[gi*W +: W];
        for (int unsigned k = 1; k < gi; k++) begin
          sr[k] <= sr[k-1];
        end
      end
    end

    assign a_vec[gi*W +: W] = sr[gi-1];
  end

  // Weight load and PE array: activations shift right, psums accumulate downward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wreg <= '{default: '0};
      d    <= '{default: '0};
      p    <= '{default: '0};
    end else if (enable) begin
      for (int unsigned j = 0; j < K; j++) begin
        wreg[j] <= weight[j*W +: W];
      end
      for (int unsigned i = 0; i < M; i++) begin
        d[i][0] <= a_vec[i*W +: W];
        for (int unsigned j = 1; j < K; j++) begin
          d[i][j] <= d[i][j-1];
        end
      end
      for (int unsigned j = 0; j < K; j++) begin
        p[0][j] <= d[0][j] * wreg[j];
        for (int unsigned i = 1; i < M; i++) begin
          p[i][j] <= p[i-1][j] + d[i][j] * wreg[j];
        end
      end
    end
  end

  // Column j leaves the array K-1-j cycles early, so it is delayed to realign.
  for (gj = 0; gj < K; gj++) begin : g_out
    if (gj == K - 1) begin : g_direct
      assign y[gj*W +: W] = p[M-1][gj];
    end else begin : g_dly
      localparam int D = K - 1 - gj;
      logic [W-1:0] dq [D];

      // Per-column deskew shift register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dq <= '{default: '0};
        end else if (enable) begin
          dq[0] <= p[M-1][gj];
          for (int unsigned k = 1; k < D; k++) begin
            dq[k] <= dq[k-1];
          end
        end
      end

      assign y[gj*W +: W] = dq[D-1];
    end
  end

  // Flag unsupported operand formats; arithmetic is unaffected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      test_mode <= 1'b0;
    end else if (enable) begin
      test_mode <= (data_type != 5'd0);
    end
  end

endmodule

// File: tb/tb_mxu_systolic_core.sv
// Bench for mxu_systolic_core: directed literal cases plus randomized traffic
// checked every cycle against a history-based dot-product model.
module tb_mxu_systolic_core;

  localparam int M = 3;
  localparam int K = 3;
  localparam int W = 4;
  localparam int L = M + K;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b1;
  logic [4:0]     data_type = '0;
  logic [M*W-1:0] input_data = '0;
  logic [K*W-1:0] weight = '0;
  logic           test_mode;
  logic [K*W-1:0] y;

  logic           enable4 = 1'b1;
  logic [4:0]     data_type4 = '0;
  logic [15:0]    in4 = '0;
  logic [15:0]    w4 = '0;
  logic           tm4;
  logic [15:0]    y4;

  int vectors = 0;
  int miscompares = 0;

  logic [M*W-1:0] xs  [$];
  logic [K*W-1:0] ws  [$];
  logic [4:0]     dts [$];

  always #5 clk = ~clk;

  mxu_systolic_core #(.M(M), .K(K), .max_data_width(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_type(data_type),
    .input_data(input_data), .weight(weight), .test_mode(test_mode), .y(y)
  );

  mxu_systolic_core #(.M(4), .K(4), .max_data_width(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable4), .data_type(data_type4),
    .input_data(in4), .weight(w4), .test_mode(tm4), .y(y4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Record every sample the array consumes since the last reset.
  always @(posedge clk) begin
    if (!reset) begin
      xs.delete();
      ws.delete();
      dts.delete();
    end else if (enable) begin
      xs.push_back(input_data);
      ws.push_back(weight);
      dts.push_back(data_type);
    end
  end

  // Model: y after n enabled edges is the dot product of sample n-L,
  // provided the weights stayed constant while that sample was in flight.
  always @(negedge clk) begin : cmp
    int n, s, acc;
    bit ok;
    logic [K*W-1:0] ey, wt;
    logic [M*W-1:0] xt;
    logic et;
    if (!reset) begin
      check("reset_y", 64'(y), 64'd0);
      check("reset_test_mode", 64'(test_mode), 64'd0);
      check("reset_y4", 64'(y4), 64'd0);
    end else begin
      n  = xs.size();
      s  = n - L;
      ok = 1'b1;
      ey = '0;
      if (s >= 0) begin
        for (int t = s; t < n; t++) if (ws[t] !== ws[s]) ok = 1'b0;
        xt = xs[s];
        wt = ws[s];
        for (int j = 0; j < K; j++) begin
          acc = 0;
          for (int i = 0; i < M; i++) acc += int'(xt[i*W +: W]) * int'(wt[j*W +: W]);
          ey[j*W +: W] = acc[W-1:0];
        end
      end
      if (ok) check("model_y", 64'(y), 64'(ey));
      et = (n == 0) ? 1'b0 : (dts[n-1] != 5'd0);
      check("model_test_mode", 64'(test_mode), 64'(et));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with random inputs and enable high.
    reset = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      data_type  = 5'($urandom_range(1, 31));
      input_data = 12'($urandom);
      weight     = 12'($urandom);
      in4        = 16'($urandom);
      w4         = 16'($urandom);
      step();
      check("reset_hold_y", 64'(y), 64'd0);
    end

    data_type  = '0;
    input_data = 12'h253;
    weight     = 12'h312;
    in4        = 16'h1353;
    w4         = 16'h5312;
    reset      = 1'b1;

    repeat (6) step();
    check("lit_EA4", 64'(y), 64'hEA4);
    input_data = 12'h353;
    repeat (2) step();
    check("lit4_C4C8", 64'(y4), 64'hC4C8);
    repeat (3) step();
    check("lit_latency_old", 64'(y), 64'hEA4);
    step();
    check("lit_1B6", 64'(y), 64'h1B6);

    input_data = 12'h564;
    weight     = 12'h111;
    repeat (6) step();
    check("lit_FFF", 64'(y), 64'hFFF);

    // Stall three cycles with new data in flight.
    input_data = 12'h253;
    repeat (3) step();
    enable = 1'b0;
    input_data = 12'h777;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_hold", 64'(y), 64'hFFF);
    end
    input_data = 12'h253;
    enable = 1'b1;
    repeat (2) step();
    check("stall_resume_old", 64'(y), 64'hFFF);
    step();
    check("stall_resume_AAA", 64'(y), 64'hAAA);

    // Overflow wrap and unsupported format.
    input_data = 12'hFFF;
    weight     = 12'hFFF;
    data_type  = 5'd1;
    step();
    check("test_mode_set", 64'(test_mode), 64'd1);
    repeat (5) step();
    check("lit_333", 64'(y), 64'h333);
    data_type = 5'd0;
    step();
    check("test_mode_clear", 64'(test_mode), 64'd0);

    // Randomized traffic with stalls, weight changes and a mid-run reset.
    for (int c = 0; c < 500; c++) begin
      enable     = ($urandom_range(0, 9) != 0);
      input_data = 12'($urandom);
      if ($urandom_range(0, 14) == 0) weight = 12'($urandom);
      if ($urandom_range(0, 7) == 0) data_type = 5'($urandom_range(0, 3));
      if (c == 250) begin
        @(posedge clk);
        #3 reset = 1'b0;
        step();
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
